fft_layer_ctrl: RTL and testbench

Per-stage address and control sequencer for the in-place radix-2 FFT engine. One instance per butterfly stage. When selected, it walks every butterfly pair of its stage and drives the RAM read addresses, the twiddle ROM address and the read/write enables, then raises `o_done` so the layer selector can advance. Data arithmetic is done elsewhere, in the shared butterfly pipe, which turns read addresses into write addresses.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_addr_gen.sv | 32 +++
 rtl/fft_layer_ctrl.sv | 122 ++++++++++++
 tb/tb_fft_layer_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT layer sequencers.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int TWID_ROM_DEPTH = 127;
  localparam int TWID_AW_MIN    = $clog2(TWID_ROM_DEPTH + 1);

  // Index width for a range 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First twiddle ROM entry of stage l in the stage-packed layout.
  function automatic int twid_base(input int l);
    return (1 << l) - 1;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly index k -> RAM pair addresses and twiddle ROM address.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int FFT_SIZE       = 8,
  parameter int MEM_OFFSET     = 8,
  parameter int LAYER_NUM      = 0,
  parameter int ADDR_SIZE      = 4,
  parameter int TWID_ADDR_SIZE = 7,
  parameter int K_W            = idx_width(FFT_SIZE / 2)
) (
  input  logic [K_W-1:0]            i_k,
  output logic [ADDR_SIZE-1:0]      o_addr_a,
  output logic [ADDR_SIZE-1:0]      o_addr_b,
  output logic [TWID_ADDR_SIZE-1:0] o_addr_tw
);

  localparam int SPAN = 1 << LAYER_NUM;

  logic [K_W-1:0] w_pos;
  logic [K_W-1:0] w_grp;

  always_comb begin
    w_pos     = i_k & K_W'(SPAN - 1);
    w_grp     = i_k >> LAYER_NUM;
    // Results wrap to the port widths by design.
    o_addr_a  = ADDR_SIZE'(MEM_OFFSET + int'(w_grp) * (2 * SPAN) + int'(w_pos));
    o_addr_b  = ADDR_SIZE'(MEM_OFFSET + int'(w_grp) * (2 * SPAN) + int'(w_pos) + SPAN);
    o_addr_tw = TWID_ADDR_SIZE'(twid_base(LAYER_NUM) + int'(w_pos));
  end

endmodule

// File: rtl/fft_layer_ctrl.sv
// Per-stage FFT address/enable sequencer: IDLE -> RUN -> DONE.
// Optional rerun after completion when FFT_LAYER_RESTART_EN is defined.
module fft_layer_ctrl
  import fft_pkg::*;
#(
  parameter int FFT_SIZE       = 8,
  parameter int MEM_OFFSET     = 8,
  parameter int LAYER_NUM      = 0,
  parameter int ADDR_SIZE      = 4,
  parameter int TWID_ADDR_SIZE = 7,
  parameter int PIPE_LATENCY   = 3
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic                      i_CS,
  output logic                      o_done,
  output logic                      o_rden,
  output logic                      o_wren,
  output logic [ADDR_SIZE-1:0]      o_rdaddr_A,
  output logic [ADDR_SIZE-1:0]      o_rdaddr_B,
  output logic [TWID_ADDR_SIZE-1:0] o_rdaddr_tw
);

  localparam int HALF  = FFT_SIZE / 2;
  localparam int K_W   = idx_width(HALF);
  localparam int LAST  = HALF + PIPE_LATENCY;
  localparam int CNT_W = idx_width(LAST + 1);

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic                      r_done, w_done_nxt;
  logic                      r_rden, w_rden_nxt;
  logic                      r_wren, w_wren_nxt;
  logic [ADDR_SIZE-1:0]      r_addr_a, r_addr_b;
  logic [TWID_ADDR_SIZE-1:0] r_addr_tw;
  logic [K_W-1:0]            w_k;
  logic [ADDR_SIZE-1:0]      w_addr_a, w_addr_b;
  logic [TWID_ADDR_SIZE-1:0] w_addr_tw;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // r_cnt holds the cycle number within the run; outputs are computed from the next one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;
    case (r_state)
      ST_IDLE: begin
        if (i_CS) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(LAST)) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
`ifdef FFT_LAYER_RESTART_EN
        if (!i_CS) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b0;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_rden_nxt = (w_state_nxt == ST_RUN) && (w_cnt_nxt <= CNT_W'(HALF));
    w_wren_nxt = (w_state_nxt == ST_RUN) && (w_cnt_nxt > CNT_W'(PIPE_LATENCY));
    w_k        = K_W'(w_cnt_nxt - CNT_W'(1));
  end

  fft_addr_gen #(
    .FFT_SIZE      (FFT_SIZE),
    .MEM_OFFSET    (MEM_OFFSET),
    .LAYER_NUM     (LAYER_NUM),
    .ADDR_SIZE     (ADDR_SIZE),
    .TWID_ADDR_SIZE(TWID_ADDR_SIZE),
    .K_W           (K_W)
  ) u_addr_gen (
    .i_k      (w_k),
    .o_addr_a (w_addr_a),
    .o_addr_b (w_addr_b),
    .o_addr_tw(w_addr_tw)
  );

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_rden    <= 1'b0;
      r_wren    <= 1'b0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_addr_tw <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_done    <= w_done_nxt;
      r_rden    <= w_rden_nxt;
      r_wren    <= w_wren_nxt;
      r_addr_a  <= w_rden_nxt ? w_addr_a  : '0;
      r_addr_b  <= w_rden_nxt ? w_addr_b  : '0;
      r_addr_tw <= w_rden_nxt ? w_addr_tw : '0;
    end
  end

  assign o_done      = r_done;
  assign o_rden      = r_rden;
  assign o_wren      = r_wren;
  assign o_rdaddr_A  = r_addr_a;
  assign o_rdaddr_B  = r_addr_b;
  assign o_rdaddr_tw = r_addr_tw;

endmodule

// File: tb/tb_fft_layer_ctrl.sv
// Directed bench: three layer instances (L=0,1,2) checked cycle by cycle against a vector table.
module tb_fft_layer_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic cs;

  always #5 clk = ~clk;

  logic       done_w [3];
  logic       rden_w [3];
  logic       wren_w [3];
  logic [3:0] a_w    [3];
  logic [3:0] b_w    [3];
  logic [6:0] tw_w   [3];

  fft_layer_ctrl #(.FFT_SIZE(8), .MEM_OFFSET(8), .LAYER_NUM(0), .ADDR_SIZE(4),
                   .TWID_ADDR_SIZE(7), .PIPE_LATENCY(3)) u_l0 (
    .i_CLK(clk), .i_RST(rst_n), .i_CS(cs), .o_done(done_w[0]), .o_rden(rden_w[0]),
    .o_wren(wren_w[0]), .o_rdaddr_A(a_w[0]), .o_rdaddr_B(b_w[0]), .o_rdaddr_tw(tw_w[0]));

  fft_layer_ctrl #(.FFT_SIZE(8), .MEM_OFFSET(8), .LAYER_NUM(1), .ADDR_SIZE(4),
                   .TWID_ADDR_SIZE(7), .PIPE_LATENCY(3)) u_l1 (
    .i_CLK(clk), .i_RST(rst_n), .i_CS(cs), .o_done(done_w[1]), .o_rden(rden_w[1]),
    .o_wren(wren_w[1]), .o_rdaddr_A(a_w[1]), .o_rdaddr_B(b_w[1]), .o_rdaddr_tw(tw_w[1]));

  fft_layer_ctrl #(.FFT_SIZE(8), .MEM_OFFSET(8), .LAYER_NUM(2), .ADDR_SIZE(4),
                   .TWID_ADDR_SIZE(7), .PIPE_LATENCY(3)) u_l2 (
    .i_CLK(clk), .i_RST(rst_n), .i_CS(cs), .o_done(done_w[2]), .o_rden(rden_w[2]),
    .o_wren(wren_w[2]), .o_rdaddr_A(a_w[2]), .o_rdaddr_B(b_w[2]), .o_rdaddr_tw(tw_w[2]));

  typedef struct {
    int a;
    int b;
    int tw;
  } vec_t;

  vec_t vec[12];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // cyc 0 = idle/reset expectations; cyc >= 8 = done held.
  task automatic check_cycle(input string tag, input int cyc);
    int ea, eb, etw;
    for (int l = 0; l < 3; l++) begin
      check($sformatf("%s L%0d c%0d rden", tag, l, cyc), int'(rden_w[l]), (cyc >= 1 && cyc <= 4) ? 1 : 0);
      check($sformatf("%s L%0d c%0d wren", tag, l, cyc), int'(wren_w[l]), (cyc >= 4 && cyc <= 7) ? 1 : 0);
      check($sformatf("%s L%0d c%0d done", tag, l, cyc), int'(done_w[l]), (cyc >= 8) ? 1 : 0);
      if (cyc >= 1 && cyc <= 4) begin
        ea  = vec[l*4 + cyc - 1].a;
        eb  = vec[l*4 + cyc - 1].b;
        etw = vec[l*4 + cyc - 1].tw;
      end else begin
        ea = 0; eb = 0; etw = 0;
      end
      check($sformatf("%s L%0d c%0d A", tag, l, cyc), int'(a_w[l]), ea);
      check($sformatf("%s L%0d c%0d B", tag, l, cyc), int'(b_w[l]), eb);
      check($sformatf("%s L%0d c%0d tw", tag, l, cyc), int'(tw_w[l]), etw);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec[0]  = '{8, 9, 0};  vec[1]  = '{10, 11, 0}; vec[2]  = '{12, 13, 0}; vec[3]  = '{14, 15, 0};
    vec[4]  = '{8, 10, 1}; vec[5]  = '{9, 11, 2};  vec[6]  = '{12, 14, 1}; vec[7]  = '{13, 15, 2};
    vec[8]  = '{8, 12, 3}; vec[9]  = '{9, 13, 4};  vec[10] = '{10, 14, 5}; vec[11] = '{11, 15, 6};

    rst_n = 1'b0;
    cs    = 1'b0;
    #12;
    check_cycle("reset", 0);
    rst_n = 1'b1;
    next_cycle();
    check_cycle("idle", 0);

    // Main run: cs dropped in cycle 2 and raised again in cycle 5, both ignored in RUN.
    cs = 1'b1;
    next_cycle();
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) cs = 1'b0;
      if (c == 5) cs = 1'b1;
      check_cycle("run", c);
      next_cycle();
    end

    // cs low for one edge, then high again.
    cs = 1'b0;
    next_cycle();
`ifdef FFT_LAYER_RESTART_EN
    check_cycle("rst_idle", 0);
    cs = 1'b1;
    next_cycle();
    for (int c = 1; c <= 9; c++) begin
      if (c == 2) cs = 1'b0;
      if (c == 5) cs = 1'b1;
      check_cycle("rerun", c);
      next_cycle();
    end
`else
    check_cycle("hold", 9);
    cs = 1'b1;
    next_cycle();
    for (int c = 0; c < 6; c++) begin
      check_cycle("hold", 9);
      next_cycle();
    end
`endif

    // Asynchronous reset in the middle of a run.
    rst_n = 1'b0;
    cs    = 1'b0;
    #3;
    rst_n = 1'b1;
    next_cycle();
    cs = 1'b1;
    next_cycle();
    check_cycle("pre_rst", 1);
    cs = 1'b0;
    next_cycle();
    check_cycle("pre_rst", 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_cycle("async_rst", 0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      check_cycle("post_rst", 0);
    end
    cs = 1'b1;
    next_cycle();
    cs = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check_cycle("after_rst", c);
      if (c < 9) next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
